lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU `result` as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a word-wide, request/acknowledge data-memory port.
- Returns sign- or zero-extended load data to writeback, with a done pulse plus an error flag for bus timeout.

Parameters:
- TIMEOUT_CYC, 255: max cycles `mem_req` stays high without `mem_ack` before the access aborts; range 1..65535.
- ADDR_W, 32: effective-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an access; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  effective address from the ALU.
- store_data  in  32  rs2 value.
- busy  out  1  high from the cycle after an accepted start until `done`.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`: timeout, illegal funct3, or misaligned (macro on).
- load_data  out  32  extended load result; valid with `done`, held until the next `done`.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (`addr[1:0]` forced to 00).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion; read data valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, high): state IDLE; outputs busy, done, err, mem_req, mem_we all 0; load_data, mem_addr, mem_be, mem_wdata all 0; timeout counter 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If start=1 in cycle N, register the operation, then go to REQ with mem_req=1 in N+1.
  - Illegal funct3 (011, 110, 111; or 100/101 with is_store) skips the memory access: RESP in N+1 with err=1.
- REQ:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until ack.
  - On mem_ack=1: capture and extend mem_rdata, drop mem_req, go to RESP.
  - If the counter reaches TIMEOUT_CYC with no ack: drop mem_req, go to RESP with err=1, load_data unchanged.
- RESP: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
  - Best-case latency: start at N, ack at N+1, done at N+2.
- Start handling: start while busy is ignored (no queueing). Start coinciding with done is also ignored; a new start is accepted only in IDLE.
- Byte enables:
  - B: 0001 shifted left by `addr[1:0]`.
  - H: 0011 shifted left by {`addr[1]`,0}.
  - W: 1111.
- Store data: B replicates `store_data[7:0]` into all four lanes; H replicates `[15:0]` into both halves.
- Load extraction: select the byte/half from `mem_rdata` by `addr[1:0]`. B/H sign-extend; BU/HU zero-extend.
- Stores leave load_data unchanged.
- Timeout counter: 16-bit, cleared on entry to REQ, increments each REQ cycle without ack, saturates.
- mem_ack outside REQ is ignored.
- Reset mid-access aborts immediately: mem_req=0, no done.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠00, issues no memory request. RESP follows in the next cycle with err=1.
- Undefined: low offending address bits are ignored. H uses `addr[1]` only; W uses the aligned word. err is never raised for misalignment.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 width codes as localparams.
  - State enum typedef {IDLE, REQ, RESP}.
  - Functions `be_gen` and `load_extend`.
- One sub-module is natural: `lsu_lane_align`, purely combinational. It produces mem_be, mem_wdata and the extended load data from funct3, `addr[1:0]`, store_data and mem_rdata. The top keeps the FSM and timeout counter.

Test Plan:
- Store word then load word: SW addr=0x100, data=0xDEADBEEF, ack after 2 cycles → mem_be=1111, mem_addr=0x100, done in the cycle after ack. LW 0x100 returns load_data=0xDEADBEEF, err=0.
- Sub-word loads, mem_rdata=0x80FF7F01:
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF80FF.
  - LHU 0x100 → 0x00007F01.
- Store half: SB 0x102 data 0x000000AB → mem_be=0100, mem_wdata=0xABABABAB. SH 0x102 → mem_be=1100.
- Timeout: TIMEOUT_CYC=4, ack never asserted → mem_req high exactly 4 cycles, then done=1, err=1, load_data unchanged.
- Misaligned/illegal: LW 0x101 with macro on → no mem_req, done+err. Macro off → mem_addr=0x100, err=0. funct3=011 → err=1.
- Reset/overlap: start asserted while busy → ignored. Async reset asserted in REQ → mem_req=0 immediately, no done. A new start after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: funct3 width codes,
// FSM state encoding and the lane/extension helper functions.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Unsigned widths exist only for loads; everything else outside B/H/W is illegal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic st);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~st;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Byte enables; halfwords use only off[1] so a stray off[0] cannot straddle lanes.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane the access might target.
  function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{sd[7:0]}};
      2'b01:   w = {2{sd[15:0]}};
      default: w = sd;
    endcase
    return w;
  endfunction

  // Select the addressed byte/half of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = rd;
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for
// stores, extracted and extended read data for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  assign o_be    = be_gen(i_funct3, i_off);
  assign o_wdata = store_rep(i_funct3, i_store_data);
  assign o_ldata = load_extend(i_funct3, i_off, i_rdata);

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: accepts one access in IDLE, runs a req/ack
// handshake with a saturating timeout, then pulses done (with err) for a cycle.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are rejected
// with err instead of silently using the aligned lanes.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  // Last REQ cycle index before the access is abandoned.
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYC - 1);

  lsu_state_e        r_state;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [15:0]       r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_load_data;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;

  logic              w_mis;
  logic              w_bad;
  logic [2:0]        w_sel_f3;
  logic [1:0]        w_sel_off;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ldata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = misaligned(funct3, addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_bad = ~f3_legal(funct3, is_store) | w_mis;

  // The aligner sees the live request while idle and the captured one afterwards.
  assign w_sel_f3  = (r_state == IDLE) ? funct3    : r_funct3;
  assign w_sel_off = (r_state == IDLE) ? addr[1:0] : r_off;

  lsu_lane_align u_align (
    .i_funct3     (w_sel_f3),
    .i_off        (w_sel_off),
    .i_store_data (store_data),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ldata      (w_ldata)
  );

  // Access FSM with timeout counter and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_cnt       <= 16'h0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_load_data <= 32'h0000_0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start) begin
            r_is_store <= is_store;
            r_funct3   <= funct3;
            r_off      <= addr[1:0];
            if (w_bad) begin
              r_state <= RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= REQ;
              r_busy      <= 1'b1;
              r_cnt       <= 16'h0000;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store;
              r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_state   <= RESP;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_is_store) begin
              r_load_data <= w_ldata;
            end
          end else if (r_cnt >= LP_CNT_LAST) begin
            r_state   <= RESP;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign load_data = r_load_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed, table-driven bench for lsu_mem_stage (TIMEOUT_CYC = 4), plus
// hand-written sequences for overlap, start-during-done and mid-access reset.
module tb_lsu_mem_stage;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int TO = 4;

  lsu_mem_stage #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_dly;   // REQ cycles before ack; >= TO means never
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int req_cycles;
    bit seen_done;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    is_store   = v.is_store;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sdata;
    mem_rdata  = v.rdata;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({t, ".mem_req"}, {31'b0, mem_req}, {31'b0, v.exp_req});
    if (v.exp_req) begin
      chk({t, ".mem_we"},    {31'b0, mem_we}, {31'b0, v.is_store});
      chk({t, ".mem_addr"},  mem_addr, {v.addr[31:2], 2'b00});
      chk({t, ".mem_be"},    {28'b0, mem_be}, {28'b0, v.exp_be});
      chk({t, ".mem_wdata"}, mem_wdata, v.exp_wdata);
      chk({t, ".busy"},      {31'b0, busy}, 32'd1);
    end
    req_cycles = 0;
    seen_done  = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (mem_req) begin
          mem_ack = (req_cycles == v.ack_dly);
          req_cycles++;
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    chk({t, ".done_seen"}, {31'b0, seen_done}, 32'd1);
    chk({t, ".req_cycles"}, req_cycles,
        v.exp_req ? ((v.ack_dly >= TO) ? TO : v.ack_dly + 1) : 0);
    chk({t, ".err"},       {31'b0, err}, {31'b0, v.exp_err});
    chk({t, ".load_data"}, load_data, v.exp_load);
    chk({t, ".busy_done"}, {30'b0, busy, mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] last_load;
    int dcount;

    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // ---- reset state ----
    #12;
    chk("rst.ctrl", {27'b0, busy, done, err, mem_req, mem_we}, 32'd0);
    chk("rst.load_data", load_data, 32'h0);
    chk("rst.mem_addr",  mem_addr,  32'h0);
    chk("rst.mem_be",    {28'b0, mem_be}, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- vector table ----
    //            st    f3      addr          sdata         rdata         dly req  be       wdata         err   load
    vq.push_back('{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h00000000, 2,  1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h00000000});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h00000000, 32'hDEADBEEF, 0,  1'b1, 4'b1111, 32'h00000000, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 3'b000, 32'h103, 32'h00000000, 32'h80FF7F01, 1,  1'b1, 4'b1000, 32'h00000000, 1'b0, 32'hFFFFFF80});
    vq.push_back('{1'b0, 3'b100, 32'h103, 32'h00000000, 32'h80FF7F01, 3,  1'b1, 4'b1000, 32'h00000000, 1'b0, 32'h00000080});
    vq.push_back('{1'b0, 3'b001, 32'h102, 32'h00000000, 32'h80FF7F01, 0,  1'b1, 4'b1100, 32'h00000000, 1'b0, 32'hFFFF80FF});
    vq.push_back('{1'b0, 3'b101, 32'h100, 32'h00000000, 32'h80FF7F01, 1,  1'b1, 4'b0011, 32'h00000000, 1'b0, 32'h00007F01});
    vq.push_back('{1'b1, 3'b000, 32'h102, 32'h000000AB, 32'h55555555, 0,  1'b1, 4'b0100, 32'hABABABAB, 1'b0, 32'h00007F01});
    vq.push_back('{1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h55555555, 2,  1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h00007F01});
    vq.push_back('{1'b0, 3'b011, 32'h100, 32'h00000000, 32'h55555555, 0,  1'b0, 4'b0000, 32'h00000000, 1'b1, 32'h00007F01});
    vq.push_back('{1'b1, 3'b100, 32'h100, 32'h00000000, 32'h55555555, 0,  1'b0, 4'b0000, 32'h00000000, 1'b1, 32'h00007F01});
`ifdef LSU_MISALIGN_TRAP_EN
    vq.push_back('{1'b0, 3'b010, 32'h101, 32'h00000000, 32'h12345678, 0,  1'b0, 4'b0000, 32'h00000000, 1'b1, 32'h00007F01});
    last_load = 32'h00007F01;
`else
    vq.push_back('{1'b0, 3'b010, 32'h101, 32'h00000000, 32'h12345678, 1,  1'b1, 4'b1111, 32'h00000000, 1'b0, 32'h12345678});
    last_load = 32'h12345678;
`endif
    // timeout: ack never arrives, load_data must keep the previous value
    vq.push_back('{1'b0, 3'b010, 32'h104, 32'h00000000, 32'hCAFEF00D, 99, 1'b1, 4'b1111, 32'h00000000, 1'b1, last_load});

    foreach (vq[i]) run_vec(i, vq[i]);

    // ---- start while busy, and start coinciding with done, are ignored ----
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h200; store_data = 32'h0; start = 1'b1;
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b000; addr = 32'h300; store_data = 32'h77; start = 1'b1;
    chk("ovl.busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("ovl.addr_held", mem_addr, 32'h200);
    chk("ovl.we_held",   {31'b0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ovl.done", {31'b0, done}, 32'd1);
    chk("ovl.load", load_data, 32'h11223344);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovl.after_done", {29'b0, mem_req, busy, done}, 32'd0);
    @(negedge clk);
    chk("ovl.no_access", {30'b0, mem_req, busy}, 32'd0);

    // ---- async reset in REQ aborts with no done ----
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rreq.mem_req", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rreq.abort", {29'b0, mem_req, busy, done}, 32'd0);
    chk("rreq.load_clr", load_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_ack === 1'b0 && done) dcount++;
      @(negedge clk);
    end
    chk("rreq.no_done", dcount, 0);

    // ---- normal access after reset ----
    v = '{1'b0, 3'b010, 32'h100, 32'h00000000, 32'h0BADC0DE, 0, 1'b1, 4'b1111, 32'h00000000, 1'b0, 32'h0BADC0DE};
    run_vec(100, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
